// File: rtl/fht_pkg.sv
// Shared definitions for the FHT write-side controller: default geometry,
// FSM encoding and a small bank-select helper.
package fht_pkg;

  localparam int FHT_A_BIT = 8;
  localparam int FHT_WORDS = 1 << FHT_A_BIT;
  localparam int FHT_LAT   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Writes always target the bank set that is not being read: {we_a, we_b}.
  function automatic logic [1:0] we_pair(input logic valid, input logic wsel);
    return {valid & ~wsel, valid & wsel};
  endfunction

endpackage

// File: rtl/fht_wr_control_if.sv
// Stage-controller side bus of the FHT write controller: read-group capture
// inputs and the write-port / status outputs.
interface fht_wr_control_if
  import fht_pkg::*;
#(
  parameter int A_BIT = FHT_A_BIT
) ();

  logic             start_stage;
  logic             st_last;
  logic             source_data;
  logic             rd_stb;
  logic [A_BIT-1:0] addr_rd;
  logic [A_BIT-1:0] addr_rd_bias;
  logic             part2_subsec;

  logic [A_BIT-1:0] addr_wr;
  logic [A_BIT-1:0] addr_wr_bias;
  logic             swap;
  logic             we_a;
  logic             we_b;
  logic             stage_done;
  logic             busy;
  logic             err;

  modport master (
    output start_stage, st_last, source_data, rd_stb, addr_rd, addr_rd_bias, part2_subsec,
    input  addr_wr, addr_wr_bias, swap, we_a, we_b, stage_done, busy, err
  );

  modport slave (
    input  start_stage, st_last, source_data, rd_stb, addr_rd, addr_rd_bias, part2_subsec,
    output addr_wr, addr_wr_bias, swap, we_a, we_b, stage_done, busy, err
  );

endinterface

// File: rtl/fht_dly_line.sv
// Valid-qualified shift register: the MSB of each word is its valid bit,
// the remaining bits are payload carried alongside it.
module fht_dly_line #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic             valid_q [DEPTH];
  logic [WIDTH-2:0] data_q  [DEPTH];

  // NOTE: only the valid bits are cleared; payload is don't-care while its
  // valid bit is low, so the data array needs no reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
    end else begin
      valid_q[0] <= din[WIDTH-1];
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: non-blocking assignments make every stage sample its predecessor's
  // pre-edge value, so the loop order cannot collapse the pipeline.
  always_ff @(posedge clk) begin
    data_q[0] <= din[WIDTH-2:0];
    for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
  end

  assign dout = {valid_q[DEPTH-1], data_q[DEPTH-1]};

endmodule

// File: rtl/fht_wr_control.sv
// FHT write-side controller: delays each read group's addresses by the
// butterfly latency and turns them into bank-set write enables and addresses.
module fht_wr_control
  import fht_pkg::*;
#(
  parameter int A_BIT = FHT_A_BIT,
  parameter int LAT   = FHT_LAT
) (
  input  logic          iCLK,
  input  logic          iRESET,
  fht_wr_control_if.slave bus
);

  localparam int WORDS = 1 << A_BIT;
  localparam int CNT_W = A_BIT + 1;
  localparam int PW    = 2 * A_BIT + 2;
  // One cycle of the latency is spent in the registered write outputs.
  localparam int DEPTH = LAT - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  state_t           state;
  logic             last;
  logic             wsel;
  cnt_t             rd_cnt;
  cnt_t             wr_cnt;

  logic [A_BIT-1:0] addr_wr_q;
  logic [A_BIT-1:0] addr_bias_q;
  logic             swap_q;
  logic             we_a_q;
  logic             we_b_q;
  logic             done_q;
  logic             busy_q;
  logic             err_q;

  logic             stb_ok;
  logic             err_evt;
  logic [PW-1:0]    pipe_in;
  logic [PW-1:0]    pipe_out;
  logic             p_valid;
  logic [A_BIT-1:0] p_addr;
  logic [A_BIT-1:0] p_bias;
  logic             p_swap;

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    stb_ok  = 1'b0;
    err_evt = 1'b0;
    stb_ok  = bus.rd_stb && ((state == RUN) || (state == IDLE && bus.start_stage));
    err_evt = (bus.rd_stb && !stb_ok) || (bus.start_stage && (state != IDLE));
    pipe_in = {stb_ok, bus.addr_rd, bus.addr_rd_bias, bus.part2_subsec};
  end

  fht_dly_line #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_dly (
    .clk  (iCLK),
    .clr  (!iRESET),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign {p_valid, p_addr, p_bias, p_swap} = pipe_out;

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state       <= IDLE;
      last        <= 1'b0;
      wsel        <= 1'b0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      addr_wr_q   <= '0;
      addr_bias_q <= '0;
      swap_q      <= 1'b0;
      we_a_q      <= 1'b0;
      we_b_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      {we_a_q, we_b_q} <= we_pair(p_valid, wsel);
      if (p_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (last) begin
          addr_wr_q   <= wr_cnt[A_BIT-1:0];
          addr_bias_q <= wr_cnt[A_BIT-1:0];
          swap_q      <= 1'b0;
        end else begin
          addr_wr_q   <= p_addr;
          addr_bias_q <= p_bias;
          swap_q      <= p_swap;
        end
      end

      if (err_evt) err_q <= 1'b1;
      done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start_stage) begin
            last   <= bus.st_last;
            wsel   <= ~bus.source_data;
            rd_cnt <= stb_ok ? cnt_t'(1) : '0;
            wr_cnt <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (stb_ok) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == cnt_t'(WORDS - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // wr_cnt reaches WORDS in the cycle the final write is on the outputs.
          if (wr_cnt == cnt_t'(WORDS)) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.addr_wr      = addr_wr_q;
  assign bus.addr_wr_bias = addr_bias_q;
  assign bus.swap         = swap_q;
  assign bus.we_a         = we_a_q;
  assign bus.we_b         = we_b_q;
  assign bus.stage_done   = done_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;

endmodule

// File: doc/fht_wr_control.md
# fht_wr_control

Write-side controller for the FHT butterfly datapath: the counterpart to the read-side stage controller. It captures each read group's addresses when the read strobe fires and delays them through a pipeline matched to the butterfly latency. It then drives write addresses and the bank-set write enables back into the ping-pong RAM banks, and reports stage completion. It sits between the stage controller and the output bank mixer / RAM write ports.

## Interface
- A_BIT, 8, bank address width; writes per stage WORDS = 2^A_BIT
- LAT, 4, butterfly latency in clocks from read strobe to result valid (range 2..8)
- iCLK  in  1  clock, all logic on rising edge
- iRESET  in  1  synchronous, active-low reset
- iSTART_STAGE  in  1  one-cycle pulse, begins a stage
- iST_LAST  in  1  last stage flag, sampled at iSTART_STAGE
- iSOURCE_DATA  in  1  bank set being read (0 = A, 1 = B), sampled at iSTART_STAGE
- iRD_STB  in  1  one-cycle pulse, one read group issued; minimum spacing 2 clocks
- iADDR_RD  in  A_BIT  read address of banks 0/2, valid with iRD_STB
- iADDR_RD_BIAS  in  A_BIT  read address of banks 1/3, valid with iRD_STB
- i2ND_PART_SUBSEC  in  1  subsector half, valid with iRD_STB
- oADDR_WR  out  A_BIT  write address, banks 0/2
- oADDR_WR_BIAS  out  A_BIT  write address, banks 1/3
- oSWAP  out  1  delayed subsector half, drives output mixer bank order
- oWE_A  out  1  write enable, bank set A
- oWE_B  out  1  write enable, bank set B
- oSTAGE_DONE  out  1  one-cycle pulse, all WORDS writes of the stage committed
- oBUSY  out  1  high from the accepted start until oSTAGE_DONE
- oERR  out  1  sticky protocol error

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on iSTART_STAGE. Latch last = iST_LAST and wsel = ~iSOURCE_DATA (writes go to the set not being read). Clear rd_cnt and wr_cnt.
- RUN: each iRD_STB pushes {iADDR_RD, iADDR_RD_BIAS, i2ND_PART_SUBSEC, valid=1} into an LAT-deep shift pipeline and increments rd_cnt. Non-strobe cycles push valid=0.
- When rd_cnt reaches WORDS (on the WORDS-th strobe), go RUN → DRAIN.
- Pipeline output with valid=1 is a write event:
  - oWE_A = valid & ~wsel; oWE_B = valid & wsel.
  - Non-last stage: oADDR_WR / oADDR_WR_BIAS = delayed read addresses (in-place), oSWAP = delayed subsector half.
  - Last stage: oADDR_WR = oADDR_WR_BIAS = wr_cnt[A_BIT-1:0] (direct order), oSWAP = 0.
  - Each write event increments wr_cnt.
- DRAIN → DONE when the write event with wr_cnt = WORDS-1 is issued. DONE lasts 1 cycle (oSTAGE_DONE = 1), then → IDLE.
- iRD_STB in IDLE, DRAIN or DONE: ignored (not pushed), oERR set.
- iSTART_STAGE while not IDLE: ignored, oERR set.
- oERR is cleared only by reset.
- Address outputs hold their last value when no write event occurs.
- rd_cnt and wr_cnt are A_BIT+1 bits wide and never wrap within a stage.

## Timing
- All outputs registered. Reset values: addresses 0, oSWAP 0, oWE_A 0, oWE_B 0, oSTAGE_DONE 0, oBUSY 0, oERR 0, FSM IDLE, pipeline valid bits 0.
- iRD_STB at cycle t → oWE_x high at cycle t+LAT, with addresses valid that same cycle.
- Final write at cycle w → oSTAGE_DONE high at w+1, oBUSY low at w+2. A new iSTART_STAGE is accepted from w+2.
- iSTART_STAGE and iRD_STB in the same cycle while IDLE: start accepted, strobe counted as the first read.
- Reset asserted mid-stage: on the next edge the pipeline is flushed, no further oWE pulses, all outputs return to reset values.
- Minimum stage length with strobes every 2 clocks: 2·(WORDS−1)+LAT+1 cycles from first strobe to oSTAGE_DONE.

## Structure
- Shared package fht_pkg: A_BIT default, WORDS, LAT default, and the FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3).
- One sub-module, fht_dly_line: parameterized width/depth valid-qualified shift register with synchronous clear. It is instantiated once with width 2·A_BIT+2.

## Test plan
- Non-last stage, iSOURCE_DATA=0, 256 strobes every 2 clocks with iADDR_RD=k, iADDR_RD_BIAS=k^8'h80 → 256 oWE_B pulses, each 4 clocks after its strobe, with matching addresses; oWE_A never high; oSTAGE_DONE once, the cycle after the 256th write.
- Last stage, iSOURCE_DATA=1, arbitrary read addresses → oWE_A pulses with oADDR_WR = oADDR_WR_BIAS = 0,1,…,255 and oSWAP=0.
- i2ND_PART_SUBSEC toggled every 64 strobes → oSWAP follows with exactly LAT-cycle delay.
- Second iSTART_STAGE mid-RUN, plus a 257th strobe in DRAIN → oERR=1 and stays 1; write count stays 256; the stage completes normally.
- iRESET low for 1 cycle after 100 strobes → all outputs 0 next cycle, no further oWE; a fresh stage afterward completes with 256 writes.
- Simultaneous iSTART_STAGE and iRD_STB from IDLE → first write at t+LAT; total 256 writes.
